// File: rtl/special_case_classifier.sv
// special_case_classifier
//
// Registered operand classifier for the FPHUB adder. Each operand of the
// incoming (X, Y) pair is classified as +/-Inf, +/-0, +/-1 or none. The
// operands and their codes are captured together in a single valid/ready
// pipeline register. A saturating counter tracks how many accepted pairs
// hold at least one special operand.
//
// Build option: define SPECIAL_ONE_DETECT_EN to enable +/-1 detection
// (codes 5 and 6). When it is undefined, +/-1 operands classify as NONE.
//
// Ports:
//   clk             clock, rising edge
//   rst             synchronous active-high reset
//   in_valid        X/Y pair presented
//   in_ready        stage can accept the pair this cycle
//   X, Y            operands {sign, exp[E-1:0], mant[M-1:0]}
//   out_valid       registered pair valid
//   out_ready       downstream consumes the pair this cycle
//   X_out, Y_out    registered operands
//   X_special_case  code for X_out
//   Y_special_case  code for Y_out
//   any_special     at least one of the registered codes is nonzero
//   special_count   saturating count of accepted pairs with a special operand
//
// States:
//   state | meaning
//   EMPTY | no pair held, out_valid = 0
//   FULL  | pair held on the outputs, out_valid = 1

module special_case_classifier #(
  parameter int M            = 23,
  parameter int E            = 8,
  parameter int special_case = 7,
  parameter int CNT_W        = 16,
  localparam int W           = E + M + 1,
  localparam int CW          = $clog2(special_case)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     X,
  input  logic [W-1:0]     Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     X_out,
  output logic [W-1:0]     Y_out,
  output logic [CW-1:0]    X_special_case,
  output logic [CW-1:0]    Y_special_case,
  output logic             any_special,
  output logic [CNT_W-1:0] special_count
);

`ifdef SPECIAL_ONE_DETECT_EN
  localparam bit ONE_EN = 1'b1;
`else
  localparam bit ONE_EN = 1'b0;
`endif

  localparam logic [CW-1:0] C_NONE   = CW'(0);
  localparam logic [CW-1:0] C_INF_P  = CW'(1);
  localparam logic [CW-1:0] C_INF_N  = CW'(2);
  localparam logic [CW-1:0] C_ZERO_P = CW'(3);
  localparam logic [CW-1:0] C_ZERO_N = CW'(4);
  localparam logic [CW-1:0] C_ONE_P  = CW'(5);
  localparam logic [CW-1:0] C_ONE_N  = CW'(6);

  // Biased exponent of 1.0
  localparam logic [E-1:0] EXP_ONE = {1'b0, {(E-1){1'b1}}};

  typedef enum logic {EMPTY, FULL} state_t;

  state_t state, next_state;
  logic   load;

  logic [CW-1:0] x_code, y_code;
  logic          any_in;

  // Priority: INF, then ZERO (denormals flush), then ONE.
  function automatic logic [CW-1:0] classify(input logic [W-1:0] op);
    logic          sign;
    logic [E-1:0]  ex;
    logic [M-1:0]  mt;
    logic [CW-1:0] code;
    sign = op[W-1];
    ex   = op[W-2:M];
    mt   = op[M-1:0];
    code = C_NONE;
    if (&ex)
      code = sign ? C_INF_N : C_INF_P;
    else if (ex == '0)
      code = sign ? C_ZERO_N : C_ZERO_P;
    else if (ONE_EN && (ex == EXP_ONE) && (mt == '0))
      code = sign ? C_ONE_N : C_ONE_P;
    return code;
  endfunction

  assign x_code = classify(X);
  assign y_code = classify(Y);
  assign any_in = (x_code != C_NONE) || (y_code != C_NONE);

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    case (state)
      EMPTY: begin
        if (in_valid) begin
          load       = 1'b1;
          next_state = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          if (in_valid) load = 1'b1;
          else          next_state = EMPTY;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      X_out          <= '0;
      Y_out          <= '0;
      X_special_case <= C_NONE;
      Y_special_case <= C_NONE;
      any_special    <= 1'b0;
    end else if (load) begin
      X_out          <= X;
      Y_out          <= Y;
      X_special_case <= x_code;
      Y_special_case <= y_code;
      any_special    <= any_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      special_count <= '0;
    else if (load && any_in && (special_count != '1))
      special_count <= special_count + CNT_W'(1);
  end

endmodule
